// File: rtl/image_pixel_loader.sv
// Binarizes a raster-order grayscale pixel stream into a DIM x DIM frame and hands it to the classifier.
// IMAGE_LOADER_DOUBLE_BUF_EN selects a two-bank buffer so filling overlaps presentation.
module image_pixel_loader #(
  parameter int bW     = 8,
  parameter int THRESH = 128,
  parameter int DIM    = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_in_valid,
  output logic          pix_in_ready,
  input  logic [bW-1:0] pix_in,
  input  logic          pix_in_last,
  output logic          image_out_valid,
  input  logic          image_out_ready,
  output logic          image [DIM][DIM],
  output logic          frame_err
);
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);
  localparam logic [bW-1:0] THR      = bW'(THRESH);

  // A beat or frame transfers on a rising clock edge where valid and ready are both high;
  // ready never depends on valid, and valid holds with stable data until the transfer.
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic          frame_err_q, frame_err_d;
  logic          accept, at_final, complete, handshake, pix_bit;

  assign accept    = pix_in_valid & pix_in_ready;
  assign at_final  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign complete  = accept & at_final;
  assign handshake = image_out_valid & image_out_ready;
  assign pix_bit   = (pix_in >= THR);
  assign frame_err = frame_err_q;

  // Early last drops the partial frame; a missing last still commits the frame.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    frame_err_d = 1'b0;
    if (accept) begin
      if (at_final) begin
        row_d       = '0;
        col_d       = '0;
        frame_err_d = ~pix_in_last;
      end else if (pix_in_last) begin
        row_d       = '0;
        col_d       = '0;
        frame_err_d = 1'b1;
      end else if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
  logic img_q [2][DIM][DIM];
  logic pres_valid_q, pres_valid_d, pending_q, pending_d;
  logic pres_bank_q, pres_bank_d, fill_bank_q, fill_bank_d;

  // pending_q marks a full fill bank waiting behind the presenting bank.
  always_comb begin
    pres_valid_d = pres_valid_q;
    pending_d    = pending_q;
    pres_bank_d  = pres_bank_q;
    fill_bank_d  = fill_bank_q;
    if (complete && (!pres_valid_q || handshake)) begin
      pres_valid_d = 1'b1;
      pres_bank_d  = fill_bank_q;
      fill_bank_d  = ~fill_bank_q;
    end else if (complete) begin
      pending_d = 1'b1;
    end else if (handshake && pending_q) begin
      pres_bank_d = fill_bank_q;
      fill_bank_d = ~fill_bank_q;
      pending_d   = 1'b0;
    end else if (handshake) begin
      pres_valid_d = 1'b0;
    end
  end

  assign pix_in_ready    = ~rst & ~pending_q;
  assign image_out_valid = pres_valid_q;

  always_comb begin
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        image[r][c] = img_q[pres_bank_q][r][c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pres_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      pres_bank_q  <= 1'b0;
      fill_bank_q  <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++)
            img_q[b][r][c] <= 1'b0;
    end else begin
      pres_valid_q <= pres_valid_d;
      pending_q    <= pending_d;
      pres_bank_q  <= pres_bank_d;
      fill_bank_q  <= fill_bank_d;
      if (accept) img_q[fill_bank_q][row_q][col_q] <= pix_bit;
    end
  end
`else
  localparam logic [0:0] ST_FILL    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0] state_q, state_d;
  logic       img_q [DIM][DIM];

  always_comb begin
    state_d = state_q;
    if (state_q == ST_FILL && complete)          state_d = ST_PRESENT;
    else if (state_q == ST_PRESENT && handshake) state_d = ST_FILL;
  end

  assign pix_in_ready    = ~rst & (state_q == ST_FILL);
  assign image_out_valid = (state_q == ST_PRESENT);

  always_comb begin
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        image[r][c] = img_q[r][c];
  end

  // Contents persist after presentation; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          img_q[r][c] <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) img_q[row_q][col_q] <= pix_bit;
    end
  end
`endif

endmodule

// File: tb/tb_image_pixel_loader.sv
// Self-checking bench for image_pixel_loader: threshold vector table, framing corner cases, frame scoreboard.
`timescale 1ns/1ps
module tb_image_pixel_loader;
  localparam int bW   = 8;
  localparam int DIM  = 28;
  localparam int NPIX = DIM * DIM;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_in_valid = 1'b0;
  logic          pix_in_ready;
  logic [bW-1:0] pix_in = '0;
  logic          pix_in_last = 1'b0;
  logic          image_out_valid;
  logic          image_out_ready = 1'b1;
  logic          image_w [DIM][DIM];
  logic          frame_err;

  int checks = 0, errors = 0, cyc = 0, err_seen = 0, rise_cyc = 0;
  int first_edge = 0, last_edge = 0, stalls = 0, base_err = 0, prev_last = 0;
  logic            prev_valid = 1'b0;
  logic [NPIX-1:0] mdl;
  logic [NPIX-1:0] exp_q[$];

  typedef struct {
    logic [bW-1:0] pix;
    logic          exp_bit;
  } vec_t;
  vec_t tbl [8];

  image_pixel_loader #(.bW(bW), .THRESH(128), .DIM(DIM)) dut (
    .clk(clk), .rst(rst),
    .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .pix_in(pix_in), .pix_in_last(pix_in_last),
    .image_out_valid(image_out_valid), .image_out_ready(image_out_ready),
    .image(image_w), .frame_err(frame_err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [NPIX-1:0] flat();
    logic [NPIX-1:0] f;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        f[r*DIM+c] = image_w[r][c];
    return f;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [NPIX-1:0] act, input logic [NPIX-1:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      first = -1;
      for (int i = NPIX - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
      $display("FAIL %s: %0d bits differ, first at row %0d col %0d got %0b expected %0b",
               name, $countones(act ^ exp), first / DIM, first % DIM, act[first], exp[first]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n beats (waiting on pix_in_ready) and builds the expected frame in mdl.
  task automatic send_frame(input int n, input int last_at, input int pat);
    logic [bW-1:0] v;
    int guard;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       v = (i % 29 == 0) ? 8'd200 : 8'd10;
        1:       v = (i < 8) ? tbl[i].pix : 8'($urandom_range(0, 255));
        2:       v = 8'd255;
        default: v = (i % 97 == 0) ? 8'd255 : 8'd0;
      endcase
      if (pat == 1 && i < 8) mdl[i] = tbl[i].exp_bit;
      else                   mdl[i] = (v >= 8'd128);
      pix_in_valid = 1'b1;
      pix_in       = v;
      pix_in_last  = (i == last_at);
      guard = 0;
      while (!pix_in_ready && guard < 2000) begin
        step();
        stalls++;
        guard++;
      end
      if (guard >= 2000) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: beat %0d never accepted", i);
      end
      step();
      if (i == 0) first_edge = cyc;
      if (i == n - 1) last_edge = cyc;
    end
    pix_in_valid = 1'b0;
    pix_in_last  = 1'b0;
  endtask

  // Scoreboard: a frame is compared when its output handshake is about to complete.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (image_out_valid && !prev_valid) rise_cyc = cyc;
      if (frame_err) err_seen++;
      if (image_out_valid && image_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: valid handshake with empty queue at cycle %0d", cyc);
        end else begin
          chk_img("frame_contents", flat(), exp_q.pop_front());
        end
      end
    end
    prev_valid = image_out_valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'd0,   1'b0};
    tbl[1] = '{8'd127, 1'b0};
    tbl[2] = '{8'd128, 1'b1};
    tbl[3] = '{8'd129, 1'b1};
    tbl[4] = '{8'd255, 1'b1};
    tbl[5] = '{8'd1,   1'b0};
    tbl[6] = '{8'd200, 1'b1};
    tbl[7] = '{8'd64,  1'b0};

    // Reset values
    rst = 1'b1;
    repeat (3) begin
      step();
      chk1("ready_in_reset", pix_in_ready, 1'b0);
    end
    rst = 1'b0;
    step();
    chk1("reset_ready", pix_in_ready, 1'b1);
    chk1("reset_valid", image_out_valid, 1'b0);
    chk1("reset_err", frame_err, 1'b0);
    chk_img("reset_image", flat(), '0);

`ifndef IMAGE_LOADER_DOUBLE_BUF_EN
    // Diagonal frame, ready high: valid in the cycle after the last beat's edge
    send_frame(NPIX, NPIX - 1, 0);
    exp_q.push_back(mdl);
    chk1("diag_valid", image_out_valid, 1'b1);
    chk1("diag_ready_low", pix_in_ready, 1'b0);
    step();
    chk_int("diag_latency", rise_cyc - first_edge, NPIX - 1);
    chk1("diag_valid_drop", image_out_valid, 1'b0);
    chk1("diag_ready_back", pix_in_ready, 1'b1);
    chk_int("diag_no_err", err_seen, 0);

    // Threshold table frame held under backpressure for 50 cycles
    image_out_ready = 1'b0;
    send_frame(NPIX, NPIX - 1, 1);
    exp_q.push_back(mdl);
    for (int k = 0; k < 50; k++) begin
      chk1("bp_valid", image_out_valid, 1'b1);
      chk1("bp_ready", pix_in_ready, 1'b0);
      chk_img("bp_hold", flat(), mdl);
      step();
    end
    for (int t = 0; t < 8; t++)
      chk1($sformatf("thresh_%0d", tbl[t].pix), image_w[0][t], tbl[t].exp_bit);
    image_out_ready = 1'b1;
    step();
    chk1("bp_release_valid", image_out_valid, 1'b0);
    chk1("bp_release_ready", pix_in_ready, 1'b1);

    // Early last on beat 100, then idle last beats, then a full frame
    base_err = err_seen;
    send_frame(101, 100, 3);
    chk1("early_err_pulse", frame_err, 1'b1);
    chk1("early_no_valid", image_out_valid, 1'b0);
    step();
    chk1("early_err_clear", frame_err, 1'b0);
    chk1("early_still_no_valid", image_out_valid, 1'b0);
    pix_in_last = 1'b1;
    repeat (3) step();
    pix_in_last = 1'b0;
    chk_int("early_err_count", err_seen - base_err, 1);
    send_frame(NPIX, NPIX - 1, 3);
    exp_q.push_back(mdl);
    chk1("after_early_valid", image_out_valid, 1'b1);
    step();
    chk_int("after_early_err_count", err_seen - base_err, 1);

    // Missing last: error pulse alongside the committed frame
    base_err = err_seen;
    send_frame(NPIX, -1, 1);
    exp_q.push_back(mdl);
    chk1("missing_err", frame_err, 1'b1);
    chk1("missing_valid", image_out_valid, 1'b1);
    step();
    chk_int("missing_err_count", err_seen - base_err, 1);

    // Reset mid-frame, then a sparse frame must show no residue
    send_frame(400, -1, 2);
    rst = 1'b1;
    step();
    chk1("midrst_ready", pix_in_ready, 1'b0);
    chk1("midrst_valid", image_out_valid, 1'b0);
    chk1("midrst_err", frame_err, 1'b0);
    chk_img("midrst_image", flat(), '0);
    rst = 1'b0;
    step();
    chk1("midrst_ready_back", pix_in_ready, 1'b1);
    send_frame(NPIX, NPIX - 1, 3);
    exp_q.push_back(mdl);
    chk1("after_rst_valid", image_out_valid, 1'b1);
    step();
`else
    // Two back-to-back frames with ready high: no stalls, 784-cycle spacing
    stalls = 0;
    send_frame(NPIX, NPIX - 1, 0);
    exp_q.push_back(mdl);
    chk1("db_valid_1", image_out_valid, 1'b1);
    prev_last = last_edge;
    send_frame(NPIX, NPIX - 1, 3);
    exp_q.push_back(mdl);
    chk1("db_valid_2", image_out_valid, 1'b1);
    chk_int("db_period", last_edge - prev_last, NPIX);
    chk_int("db_stalls", stalls, 0);
    step();
`endif

    repeat (3) step();
    chk_int("frames_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
